// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings and constants for the LED PIO sequencer
package led_seq_pkg;
    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_SHIFT  = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;
    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
    localparam logic [7:0] SEED_OFF    = 8'h00;
    localparam logic [7:0] SEED_BLINK  = 8'hFF;
    localparam logic [7:0] SEED_SHIFT  = 8'h01;
    localparam logic [7:0] SEED_BOUNCE = 8'h01;
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    function automatic logic [7:0] mode_seed(input logic [1:0] m);
        return m == MODE_OFF ? SEED_OFF : m == MODE_BLINK ? SEED_BLINK :
               m == MODE_SHIFT ? SEED_SHIFT : SEED_BOUNCE;
    endfunction
endpackage

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled off/blink/shift/bounce pattern engine with write-pending flag
module led_pattern_gen
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       freeze,
    input  logic       clear_pending,
    output logic [7:0] cur_pattern,
    output logic       pending
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] pat_q, pat_d;
    logic dir_q, dir_d, pend_q, pend_d, load_q, load_d;
    logic tick, load, step, dir_n;
    always_comb begin
        tick = cnt_q == CW'(TICK_DIV - 1);
        load = load_q || mode != mode_q;
        step = tick && !freeze && mode_q != MODE_OFF;
        // direction flips at either end, so 0x80 steps to 0x40 and 0x01 to 0x02
        dir_n = pat_q == 8'h80 ? 1'b0 : pat_q == 8'h01 ? 1'b1 : dir_q;
        load_d = 1'b0;
        mode_d = mode;
        cnt_d = (load || tick) ? '0 : cnt_q + 1'b1;
        pat_d = load ? mode_seed(mode) :
                !step ? pat_q :
                mode_q == MODE_BLINK ? ~pat_q :
                mode_q == MODE_SHIFT ? {pat_q[6:0], pat_q[7]} :
                dir_n ? pat_q << 1 : pat_q >> 1;
        dir_d = load ? 1'b1 : (step && mode_q == MODE_BOUNCE) ? dir_n : dir_q;
        pend_d = (load || step) ? 1'b1 : clear_pending ? 1'b0 : pend_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            mode_q <= MODE_OFF;
            pat_q  <= SEED_OFF;
            dir_q  <= 1'b1;
            pend_q <= 1'b0;
            load_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            pend_q <= pend_d;
            load_q <= load_d;
        end
    end
    assign cur_pattern = pat_q;
    assign pending = pend_q;
endmodule

// File: rtl/led_pio_sequencer.sv
// led_pio_sequencer: arbitrates pattern engine and host override onto the LED PIO write port
module led_pio_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV    = 5000000,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        host_valid,
    input  logic [7:0]  host_data,
    output logic        host_ready,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        override_active,
    output logic [7:0]  cur_pattern
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    state_t state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic host_wr_q, host_wr_d, restore_q, restore_d;
    logic cs_q, cs_d, wn_q, wn_d, ready_q, ready_d, ovr_q, ovr_d;
    logic [1:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic pending, accept, pick_pat;
    led_pattern_gen #(.TICK_DIV(TICK_DIV)) u_gen (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .freeze       (state_q == HOLD),
        .clear_pending(pick_pat),
        .cur_pattern  (cur_pattern),
        .pending      (pending)
    );
    always_comb begin
        accept = host_valid && ready_q;
        // restore_q requests a pattern rewrite once an override window expires
        pick_pat = state_q == IDLE && !accept && (pending || restore_q);
        state_d = state_q;
        hold_d = hold_q;
        host_wr_d = host_wr_q;
        restore_d = restore_q;
        wd_d = wd_q;
        if (accept) begin
            state_d = WRITE;
            host_wr_d = 1'b1;
            wd_d = {24'h0, host_data};
        end else if (pick_pat) begin
            state_d = WRITE;
            host_wr_d = 1'b0;
            restore_d = 1'b0;
            wd_d = {24'h0, cur_pattern};
        end else if (state_q == WRITE) begin
            state_d = host_wr_q ? HOLD : IDLE;
            hold_d = HW'(HOLD_CYCLES - 1);
        end else if (state_q == HOLD) begin
            state_d = hold_q == '0 ? IDLE : HOLD;
            restore_d = hold_q == '0 ? 1'b1 : restore_q;
            hold_d = hold_q == '0 ? hold_q : hold_q - 1'b1;
        end
        cs_d = state_d == WRITE;
        wn_d = state_d != WRITE;
        addr_d = state_d == WRITE ? PIO_DATA_ADDR : addr_q;
        ready_d = state_d != WRITE;
        ovr_d = state_d == HOLD;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            host_wr_q <= 1'b0;
            restore_q <= 1'b0;
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            addr_q    <= PIO_DATA_ADDR;
            wd_q      <= '0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            host_wr_q <= host_wr_d;
            restore_q <= restore_d;
            cs_q      <= cs_d;
            wn_q      <= wn_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
        end
    end
    assign pio_chipselect = cs_q;
    assign pio_write_n = wn_q;
    assign pio_address = addr_q;
    assign pio_writedata = wd_q;
    assign host_ready = ready_q;
    assign override_active = ovr_q;
endmodule

// File: tb/tb_led_pio_sequencer.sv
// tb_led_pio_sequencer: directed checks of pattern strobes, host override and reset behaviour
module tb_led_pio_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic host_valid = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic host_ready, pio_chipselect, pio_write_n, override_active;
    logic [1:0] pio_address;
    logic [31:0] pio_writedata;
    logic [7:0] cur_pattern;
    int checks = 0;
    int failures = 0;
    localparam logic [7:0] SHIFT_EXP [0:8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    localparam logic [7:0] BOUNCE_EXP [0:15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    led_pio_sequencer #(.TICK_DIV(4), .HOLD_CYCLES(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .mode           (mode),
        .host_valid     (host_valid),
        .host_data      (host_data),
        .host_ready     (host_ready),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .override_active(override_active),
        .cur_pattern    (cur_pattern)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // leaves the bench in the first cycle with reset low
    task automatic do_reset(input logic [1:0] m);
        reset = 1'b1;
        mode = m;
        host_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        mode = 2'd0;
        host_valid = 1'b0;
        host_data = 8'h00;
        step();
        step();
        checks++;
        if ({pio_chipselect, pio_write_n, pio_address} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_ctrl cs=%b wn=%b addr=%0d want cs=0 wn=1 addr=0", pio_chipselect, pio_write_n, pio_address);
        end
        checks++;
        if (pio_writedata !== 32'h0) begin
            failures++;
            $display("FAIL reset_wd got=%h want=0", pio_writedata);
        end
        checks++;
        if (host_ready !== 1'b0 || override_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags ready=%b ovr=%b want 0 0", host_ready, override_active);
        end
        checks++;
        if (cur_pattern !== 8'h00) begin
            failures++;
            $display("FAIL reset_pattern got=%h want=00", cur_pattern);
        end
    endtask
    task automatic test_shift();
        do_reset(2'd2);
        step();
        for (int k = 0; k < 9; k++) begin
            if (k > 0)
                for (int j = 0; j < 3; j++) begin
                    step();
                    checks++;
                    if (pio_chipselect !== 1'b0) begin
                        failures++;
                        $display("FAIL shift_gap%0d cs=%b want=0", k, pio_chipselect);
                    end
                end
            step();
            checks++;
            if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_address !== 2'd0 || pio_writedata !== {24'h0, SHIFT_EXP[k]}) begin
                failures++;
                $display("FAIL shift_strobe%0d cs=%b wn=%b wd=%h want wd=%h", k, pio_chipselect, pio_write_n, pio_writedata, SHIFT_EXP[k]);
            end
        end
    endtask
    task automatic test_bounce();
        mode = 2'd3;
        step();
        for (int k = 0; k < 16; k++) begin
            if (k > 0)
                for (int j = 0; j < 3; j++) begin
                    step();
                    checks++;
                    if (pio_chipselect !== 1'b0) begin
                        failures++;
                        $display("FAIL bounce_gap%0d cs=%b want=0", k, pio_chipselect);
                    end
                end
            step();
            checks++;
            if (pio_chipselect !== 1'b1 || pio_writedata !== {24'h0, BOUNCE_EXP[k]}) begin
                failures++;
                $display("FAIL bounce_strobe%0d cs=%b wd=%h want wd=%h", k, pio_chipselect, pio_writedata, BOUNCE_EXP[k]);
            end
        end
    endtask
    task automatic test_host_priority();
        do_reset(2'd1);
        step();
        checks++;
        if (host_ready !== 1'b1) begin
            failures++;
            $display("FAIL prio_ready got=%b want=1", host_ready);
        end
        host_valid = 1'b1;
        host_data = 8'hA5;
        step();
        host_valid = 1'b0;
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'hA5 || host_ready !== 1'b0) begin
            failures++;
            $display("FAIL prio_host_strobe cs=%b wd=%h ready=%b want cs=1 wd=a5 ready=0", pio_chipselect, pio_writedata, host_ready);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (override_active !== 1'b1 || pio_chipselect !== 1'b0 || host_ready !== 1'b1) begin
                failures++;
                $display("FAIL prio_hold%0d ovr=%b cs=%b ready=%b want 1 0 1", i, override_active, pio_chipselect, host_ready);
            end
        end
        step();
        checks++;
        if (override_active !== 1'b0 || pio_chipselect !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle ovr=%b cs=%b want 0 0", override_active, pio_chipselect);
        end
        step();
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'hFF) begin
            failures++;
            $display("FAIL prio_restore cs=%b wd=%h want cs=1 wd=ff", pio_chipselect, pio_writedata);
        end
    endtask
    task automatic test_mode_off();
        int extra;
        extra = 0;
        mode = 2'd0;
        step();
        checks++;
        if (pio_chipselect !== 1'b0) begin
            failures++;
            $display("FAIL off_pre cs=%b want=0", pio_chipselect);
        end
        step();
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h0 || cur_pattern !== 8'h00) begin
            failures++;
            $display("FAIL off_strobe cs=%b wd=%h pat=%h want cs=1 wd=0 pat=00", pio_chipselect, pio_writedata, cur_pattern);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (pio_chipselect !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL off_quiet strobes=%0d want=0", extra);
        end
    endtask
    task automatic test_hold_reload();
        do_reset(2'd0);
        step();
        host_valid = 1'b1;
        host_data = 8'h5A;
        step();
        host_valid = 1'b0;
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h5A) begin
            failures++;
            $display("FAIL reload_first cs=%b wd=%h want cs=1 wd=5a", pio_chipselect, pio_writedata);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (override_active !== 1'b1 || pio_chipselect !== 1'b0) begin
                failures++;
                $display("FAIL reload_hold_a%0d ovr=%b cs=%b want 1 0", i, override_active, pio_chipselect);
            end
        end
        host_valid = 1'b1;
        host_data = 8'h3C;
        step();
        host_valid = 1'b0;
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h3C || override_active !== 1'b0) begin
            failures++;
            $display("FAIL reload_second cs=%b wd=%h ovr=%b want cs=1 wd=3c ovr=0", pio_chipselect, pio_writedata, override_active);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (override_active !== 1'b1 || pio_chipselect !== 1'b0) begin
                failures++;
                $display("FAIL reload_hold_b%0d ovr=%b cs=%b want 1 0", i, override_active, pio_chipselect);
            end
        end
        step();
        checks++;
        if (override_active !== 1'b0 || pio_chipselect !== 1'b0) begin
            failures++;
            $display("FAIL reload_idle ovr=%b cs=%b want 0 0", override_active, pio_chipselect);
        end
        step();
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h0) begin
            failures++;
            $display("FAIL reload_restore cs=%b wd=%h want cs=1 wd=0", pio_chipselect, pio_writedata);
        end
    endtask
    task automatic test_reset_in_hold();
        do_reset(2'd3);
        step();
        host_valid = 1'b1;
        host_data = 8'h77;
        step();
        host_valid = 1'b0;
        step();
        step();
        checks++;
        if (override_active !== 1'b1) begin
            failures++;
            $display("FAIL rsthold_pre ovr=%b want=1", override_active);
        end
        reset = 1'b1;
        step();
        checks++;
        if (override_active !== 1'b0 || host_ready !== 1'b0 || pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin
            failures++;
            $display("FAIL rsthold_drop ovr=%b ready=%b cs=%b wn=%b want 0 0 0 1", override_active, host_ready, pio_chipselect, pio_write_n);
        end
        reset = 1'b0;
        step();
        checks++;
        if (pio_chipselect !== 1'b0) begin
            failures++;
            $display("FAIL rsthold_gap cs=%b want=0", pio_chipselect);
        end
        step();
        checks++;
        if (pio_chipselect !== 1'b1 || pio_writedata !== 32'h01) begin
            failures++;
            $display("FAIL rsthold_load cs=%b wd=%h want cs=1 wd=01", pio_chipselect, pio_writedata);
        end
    endtask
    initial begin
        test_reset();
        test_shift();
        test_bounce();
        test_host_priority();
        test_mode_off();
        test_hold_reload();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
